// File: rtl/time_counter.sv
// BCD time-of-day counter: seconds/minutes/hours, each advanced only by its own strobe edge.
// Define HOUR12_EN for 12-hour counting with an AM/PM flag; default is 24-hour.
module time_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_s,
  input  logic       clk_m,
  input  logic       clk_h,
  output logic [7:0] second,
  output logic [7:0] minute,
  output logic [7:0] hour,
  output logic       s_bit,
  output logic       m_bit,
  output logic       pm
);

`ifdef HOUR12_EN
  localparam logic [7:0] HOUR_RST = 8'h12;
`else
  localparam logic [7:0] HOUR_RST = 8'h00;
`endif

  logic       s_prev_q, m_prev_q, h_prev_q;
  logic       s_prev_d, m_prev_d, h_prev_d;
  logic [7:0] second_q, minute_q, hour_q;
  logic [7:0] second_d, minute_d, hour_d;
  logic       s_bit_q, m_bit_q, s_bit_d, m_bit_d;
  logic       pm_q, pm_d;
  logic       s_fire, m_fire, h_fire;
  logic [8:0] sec_inc, min_inc;

  // Returns {wrap, next}; a non-BCD or out-of-range value recovers to 00 without wrap.
  function automatic logic [8:0] inc60(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 9'h000;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return {1'b1, 8'h00};
      return {1'b0, v[7:4] + 4'd1, 4'h0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    s_fire   = clk_s & ~s_prev_q;
    m_fire   = clk_m & ~m_prev_q;
    h_fire   = clk_h & ~h_prev_q;
    s_prev_d = clk_s;
    m_prev_d = clk_m;
    h_prev_d = clk_h;
    sec_inc  = inc60(second_q);
    min_inc  = inc60(minute_q);
    second_d = s_fire ? sec_inc[7:0] : second_q;
    minute_d = m_fire ? min_inc[7:0] : minute_q;
    s_bit_d  = s_fire & sec_inc[8];
    m_bit_d  = m_fire & min_inc[8];
    hour_d   = hour_q;
    pm_d     = pm_q;
    if (h_fire) begin
`ifdef HOUR12_EN
      if (hour_q[7:4] > 4'd1 || hour_q[3:0] > 4'd9 || hour_q == 8'h00 ||
          (hour_q[7:4] == 4'd1 && hour_q[3:0] > 4'd2))
        hour_d = 8'h12;
      else if (hour_q == 8'h12)
        hour_d = 8'h01;
      else if (hour_q == 8'h11) begin
        hour_d = 8'h12;
        pm_d   = ~pm_q;
      end else if (hour_q[3:0] == 4'd9)
        hour_d = 8'h10;
      else
        hour_d = {hour_q[7:4], hour_q[3:0] + 4'd1};
`else
      // 23 and every invalid code both land on 00.
      if (hour_q[7:4] > 4'd2 || hour_q[3:0] > 4'd9 ||
          (hour_q[7:4] == 4'd2 && hour_q[3:0] >= 4'd3))
        hour_d = 8'h00;
      else if (hour_q[3:0] == 4'd9)
        hour_d = {hour_q[7:4] + 4'd1, 4'h0};
      else
        hour_d = {hour_q[7:4], hour_q[3:0] + 4'd1};
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_prev_q <= 1'b0;
      m_prev_q <= 1'b0;
      h_prev_q <= 1'b0;
      second_q <= 8'h00;
      minute_q <= 8'h00;
      hour_q   <= HOUR_RST;
      s_bit_q  <= 1'b0;
      m_bit_q  <= 1'b0;
      pm_q     <= 1'b0;
    end else begin
      s_prev_q <= s_prev_d;
      m_prev_q <= m_prev_d;
      h_prev_q <= h_prev_d;
      second_q <= second_d;
      minute_q <= minute_d;
      hour_q   <= hour_d;
      s_bit_q  <= s_bit_d;
      m_bit_q  <= m_bit_d;
      pm_q     <= pm_d;
    end
  end

  assign second = second_q;
  assign minute = minute_q;
  assign hour   = hour_q;
  assign s_bit  = s_bit_q;
  assign m_bit  = m_bit_q;
`ifdef HOUR12_EN
  assign pm     = pm_q;
`else
  assign pm     = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: directed scenarios plus random strobes against an integer time model.
module tb_time_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_s = 1'b0, clk_m = 1'b0, clk_h = 1'b0;
  logic [7:0] second, minute, hour;
  logic       s_bit, m_bit, pm;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: plain integer time, converted to BCD only for comparison.
  int sec_m, min_m, hr_m;
  bit pm_m, sb_m, mb_m;
  bit ps, pmv, ph;

  time_counter dut (
    .clk(clk), .reset(reset), .clk_s(clk_s), .clk_m(clk_m), .clk_h(clk_h),
    .second(second), .minute(minute), .hour(hour),
    .s_bit(s_bit), .m_bit(m_bit), .pm(pm)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sec_m = 0; min_m = 0;
`ifdef HOUR12_EN
    hr_m = 12;
`else
    hr_m = 0;
`endif
    pm_m = 0; sb_m = 0; mb_m = 0;
    ps = 0; pmv = 0; ph = 0;
  endtask

  task automatic model_clock();
    sb_m = 0; mb_m = 0;
    if (clk_s && !ps) begin
      if (sec_m == 59) begin sec_m = 0; sb_m = 1; end
      else sec_m++;
    end
    if (clk_m && !pmv) begin
      if (min_m == 59) begin min_m = 0; mb_m = 1; end
      else min_m++;
    end
    if (clk_h && !ph) begin
`ifdef HOUR12_EN
      if (hr_m == 11) begin hr_m = 12; pm_m = !pm_m; end
      else if (hr_m == 12) hr_m = 1;
      else hr_m++;
`else
      hr_m = (hr_m + 1) % 24;
`endif
    end
    ps = clk_s; pmv = clk_m; ph = clk_h;
  endtask

  task automatic check_all();
    chk("second", second, bcd(sec_m));
    chk("minute", minute, bcd(minute_dummy(min_m)));
    chk("hour", hour, bcd(hr_m));
    chk("s_bit", s_bit, sb_m);
    chk("m_bit", m_bit, mb_m);
    chk("pm", pm, pm_m);
  endtask

  function automatic int minute_dummy(input int v);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) model_clock();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_s(input int n);
    for (int i = 0; i < n; i++) begin clk_s = 1; step(); clk_s = 0; step(); end
  endtask
  task automatic pulse_m(input int n);
    for (int i = 0; i < n; i++) begin clk_m = 1; step(); clk_m = 0; step(); end
  endtask
  task automatic pulse_h(input int n);
    for (int i = 0; i < n; i++) begin clk_h = 1; step(); clk_h = 0; step(); end
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1;

    // count to 37 seconds, then async reset between edges
    pulse_s(37);
    chk("sec37", second, 8'h37);
    #2 reset = 0;
    #1;
    model_reset();
    chk("rst_second", second, 8'h00);
    chk("rst_minute", minute, 8'h00);
    chk("rst_sbit", s_bit, 1'b0);
    chk("rst_mbit", m_bit, 1'b0);
    check_all();
    @(negedge clk);
    reset = 1;

    // seconds wrap 59 -> 00 with one-cycle s_bit
    pulse_s(59);
    chk("sec59", second, 8'h59);
    clk_s = 1; step();
    chk("wrap_sec", second, 8'h00);
    chk("wrap_sbit", s_bit, 1'b1);
    clk_s = 0; step();
    chk("wrap_sbit_fall", s_bit, 1'b0);
    chk("wrap_min_unch", minute, 8'h00);

    // level strobe held 10 cycles advances once
    clk_m = 1;
    for (int i = 0; i < 10; i++) step();
    clk_m = 0; step();
    chk("level_min", minute, 8'h01);

    // hour wrap
`ifdef HOUR12_EN
    pulse_h(11);
    chk("hr11", hour, 8'h11);
    pulse_h(1);
    chk("hr12pm", {pm, hour}, 9'h112);
    pulse_h(1);
    chk("hr01pm", {pm, hour}, 9'h101);
`else
    pulse_h(23);
    chk("hr23", hour, 8'h23);
    clk_h = 1; step();
    chk("hr00", hour, 8'h00);
    chk("hr_no_carry", {s_bit, m_bit}, 2'b00);
    clk_h = 0; step();
`endif

    // simultaneous second and minute wrap
    pulse_s(59);
    pulse_m(58);
    clk_s = 1; clk_m = 1; step();
    chk("sim_time", {second, minute}, 16'h0000);
    chk("sim_bits", {s_bit, m_bit}, 2'b11);
    clk_s = 0; clk_m = 0; step();
    chk("sim_bits_fall", {s_bit, m_bit}, 2'b00);

    // random strobes with occasional async resets
    for (int i = 0; i < 3000; i++) begin
      clk_s = 1'($urandom_range(0, 1));
      clk_m = 1'($urandom_range(0, 1));
      clk_h = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        reset = 1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
